// File: rtl/fetch_stage_pkg.sv
// Shared processor definitions: word width, fetch FSM encoding, default reset PC.
package fetch_stage_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register, with
// BOOT/RUN/HALT sequencing, stall hold and branch redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] pc_out,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc,
    output logic [WORD_W-1:0] id_pc_plus1,
    output logic              halted,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_t state, state_nxt;

    logic [WORD_W-1:0] pc_p0;
    logic [WORD_W-1:0] pc_inc_p0;
    logic              do_redirect;
    logic              do_halt;
    logic              do_advance;

    assign pc_out    = pc_p0;
    assign pc_inc_p0 = pc_p0 + 16'd1;
    assign halted    = (state == HALT);

    // Priority decode: redirect beats halt beats stall; HALT ignores everything but rst.
    always_comb begin
        state_nxt   = state;
        do_redirect = 1'b0;
        do_halt     = 1'b0;
        do_advance  = 1'b0;
        case (state)
            BOOT: begin
                state_nxt   = RUN;
                do_redirect = redirect_valid;
            end
            RUN: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                end else if (halt) begin
                    do_halt   = 1'b1;
                    state_nxt = HALT;
                end else if (!stall) begin
                    do_advance = 1'b1;
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus1 <= '0;
            fetch_count <= '0;
        end else if (do_redirect) begin
            pc_p0    <= redirect_pc;
            id_valid <= 1'b0;
        end else if (do_halt) begin
            id_valid <= 1'b0;
        end else if (do_advance) begin
            pc_p0       <= pc_inc_p0;
            id_valid    <= 1'b1;
            id_instr    <= instr_in;
            id_pc       <= pc_p0;
            id_pc_plus1 <= pc_inc_p0;
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of fetched addresses plus
// cycle-by-cycle checks of PC, IF/ID, halt and reset behaviour.
module tb_fetch_stage;

    logic        clk;
    logic        rst, stall, redirect_valid, halt;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out, instr_in, id_instr, id_pc, id_pc_plus1, fetch_count;
    logic        id_valid, halted;

    logic        rst2;
    logic [15:0] pc_out2, instr_in2, id_instr2, id_pc2, id_pc_plus1_2, fetch_count2;
    logic        id_valid2, halted2;

    logic [15:0] mem [0:255];
    logic [15:0] sb_q [$];
    logic [15:0] last_fc;
    int          vectors;
    int          miscompares;

    assign instr_in  = mem[pc_out[7:0]];
    assign instr_in2 = pc_out2 ^ 16'hC3C3;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .instr_in(instr_in),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus1(id_pc_plus1), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst2), .pc_out(pc_out2), .instr_in(instr_in2),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .halt(1'b0), .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2),
        .id_pc_plus1(id_pc_plus1_2), .halted(halted2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sb();
        logic [15:0] a;
        if (id_valid && fetch_count !== last_fc) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_unexpected observed_pc=%h expected=none", id_pc);
            end else begin
                a = sb_q.pop_front();
                chk("sb_id_pc", id_pc, a);
                chk("sb_id_instr", id_instr, mem[a[7:0]]);
                chk("sb_id_pc_plus1", id_pc_plus1, a + 16'd1);
            end
        end
        last_fc = fetch_count;
    endtask

    task automatic idle();
        tick();
        check_sb();
    endtask

    task automatic adv(input logic [15:0] a);
        sb_q.push_back(a);
        tick();
        check_sb();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc_out"}, pc_out, 16'h0000);
        chk1({tag, "_id_valid"}, id_valid, 1'b0);
        chk({tag, "_id_instr"}, id_instr, 16'h0000);
        chk({tag, "_id_pc"}, id_pc, 16'h0000);
        chk({tag, "_id_pc_plus1"}, id_pc_plus1, 16'h0000);
        chk({tag, "_fetch_count"}, fetch_count, 16'h0000);
        chk1({tag, "_halted"}, halted, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_fc     = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;

        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; halt = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        // BOOT cycle holds PC, then free-run
        idle();
        chk("boot_pc_out", pc_out, 16'h0000);
        chk1("boot_id_valid", id_valid, 1'b0);
        adv(16'h0000);
        chk("run_pc_out1", pc_out, 16'h0001);
        chk("run_id_instr0", id_instr, 16'h1111);
        adv(16'h0001);
        chk("run_pc_out2", pc_out, 16'h0002);
        adv(16'h0002);
        chk("run_pc_out3", pc_out, 16'h0003);
        chk("run_fetch_count3", fetch_count, 16'd3);
        adv(16'h0003);
        adv(16'h0004);
        chk("run_pc_out5", pc_out, 16'h0005);

        // three-cycle stall at pc=5
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("stall_pc_out", pc_out, 16'h0005);
            chk("stall_id_pc", id_pc, 16'h0004);
            chk("stall_id_instr", id_instr, 16'hA004);
            chk1("stall_id_valid", id_valid, 1'b1);
            chk("stall_fetch_count", fetch_count, 16'd5);
        end
        stall = 1'b0;
        adv(16'h0005);
        chk("release_pc_out", pc_out, 16'h0006);
        chk("release_fetch_count", fetch_count, 16'd6);

        // redirect wins over stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
        idle();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("redir_pc_out", pc_out, 16'h0040);
        chk1("redir_id_valid", id_valid, 1'b0);
        chk("redir_fetch_count", fetch_count, 16'd6);
        adv(16'h0040);
        chk("redir_next_pc_out", pc_out, 16'h0041);
        chk1("redir_next_id_valid", id_valid, 1'b1);

        // halt and redirect together: redirect wins
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0020;
        idle();
        halt = 1'b0; redirect_valid = 1'b0;
        chk("hr_pc_out", pc_out, 16'h0020);
        chk1("hr_halted", halted, 1'b0);
        chk1("hr_id_valid", id_valid, 1'b0);
        adv(16'h0020);
        chk("hr_next_pc_out", pc_out, 16'h0021);
        chk1("hr_next_halted", halted, 1'b0);
        chk("hr_fetch_count", fetch_count, 16'd8);

        // halt at pc=9, then poke it with redirect/stall/halt
        redirect_valid = 1'b1; redirect_pc = 16'h0009;
        idle();
        redirect_valid = 1'b0;
        chk("pre_halt_pc_out", pc_out, 16'h0009);
        halt = 1'b1;
        idle();
        halt = 1'b0;
        chk1("halt_halted", halted, 1'b1);
        chk("halt_pc_out", pc_out, 16'h0009);
        chk1("halt_id_valid", id_valid, 1'b0);
        chk("halt_fetch_count", fetch_count, 16'd8);
        redirect_valid = 1'b1; redirect_pc = 16'h0077;
        idle();
        redirect_valid = 1'b0;
        chk("halt_redir_pc_out", pc_out, 16'h0009);
        chk1("halt_redir_halted", halted, 1'b1);
        stall = 1'b1;
        idle();
        stall = 1'b0;
        halt = 1'b1;
        idle();
        halt = 1'b0;
        idle();
        chk("halt_hold_pc_out", pc_out, 16'h0009);
        chk1("halt_hold_id_valid", id_valid, 1'b0);
        chk("halt_hold_fetch_count", fetch_count, 16'd8);
        chk1("halt_hold_halted", halted, 1'b1);

        // reset out of HALT with stall and halt also asserted
        stall = 1'b1; halt = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; halt = 1'b0;
        last_fc = 16'h0000;
        chk_reset_state("halt_reset");

        // redirect during BOOT applies and still enters RUN
        redirect_valid = 1'b1; redirect_pc = 16'h0030;
        idle();
        redirect_valid = 1'b0;
        chk("boot_redir_pc_out", pc_out, 16'h0030);
        chk1("boot_redir_id_valid", id_valid, 1'b0);
        adv(16'h0030);
        chk("boot_redir_next_pc_out", pc_out, 16'h0031);
        chk("boot_redir_fetch_count", fetch_count, 16'd1);
        stall = 1'b1;
        chk("sb_drained", 16'(sb_q.size()), 16'd0);

        // PC wrap with RESET_PC = FFFF
        rst2 = 1'b0;
        chk("wrap_boot_pc_out", pc_out2, 16'hFFFF);
        chk1("wrap_boot_id_valid", id_valid2, 1'b0);
        tick();
        chk("wrap_run_pc_out", pc_out2, 16'hFFFF);
        tick();
        chk("wrap_pc_out", pc_out2, 16'h0000);
        chk("wrap_id_pc", id_pc2, 16'hFFFF);
        chk("wrap_id_pc_plus1", id_pc_plus1_2, 16'h0000);
        chk("wrap_id_instr", id_instr2, 16'h3C3C);
        chk1("wrap_id_valid", id_valid2, 1'b1);
        tick();
        chk("wrap_pc_out_next", pc_out2, 16'h0001);
        chk("wrap_id_pc_next", id_pc2, 16'h0000);
        chk("wrap_id_pc_plus1_next", id_pc_plus1_2, 16'h0001);
        chk("wrap_fetch_count", fetch_count2, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
